// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: on irq_i reads the controller FLAG and MASK registers over
// Wishbone, hands the highest-priority pending source to the consumer, then clears it.

`ifndef REG_IRQC_FLAG
`define REG_IRQC_FLAG 16'h0000
`endif
`ifndef REG_IRQC_MASK
`define REG_IRQC_MASK 16'h0004
`endif

module irq_dispatcher #(
    parameter int          NUM_SOURCES = 5,
    parameter logic [15:0] FLAG_ADDR   = `REG_IRQC_FLAG,
    parameter logic [15:0] MASK_ADDR   = `REG_IRQC_MASK,
    parameter int          TIMEOUT     = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable_i,
    input  logic        irq_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        vec_valid_o,
    output logic [3:0]  vec_o,
    input  logic        vec_ack_i,
    output logic        spurious_o,
    output logic        err_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_FLAG, S_RD_MASK, S_SELECT, S_DISPATCH, S_CLR_FLAG, S_HOLDOFF
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [15:0]            adr_q, adr_d, dat_q, dat_d, cnt_q, cnt_d;
    logic [NUM_SOURCES-1:0] flag_q, flag_d, mask_q, mask_d, pending_s;
    logic                   vec_valid_q, vec_valid_d;
    logic [3:0]             vec_q, vec_d;
    logic                   spurious_q, spurious_d, err_q, err_d, busy_q, busy_d;
    logic [15:0]            clr_word_s;
    logic                   dat_unused_s;

    function automatic logic [3:0] lowest_set(input logic [NUM_SOURCES-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign pending_s    = flag_q & mask_q;
    assign clr_word_s   = ~(16'd1 << vec_q);
    assign dat_unused_s = ^wbm_dat_i;

    // Next-state and next-output logic; every bus state spends its first cycle with cyc low
    // unless the previous state already launched the transaction.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        mask_d      = mask_q;
        vec_valid_d = vec_valid_q;
        vec_d       = vec_q;
        spurious_d  = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i && irq_i) begin
                    state_d = S_RD_FLAG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_FLAG, S_RD_MASK, S_CLR_FLAG: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    cnt_d = 16'd0;
                    we_d  = (state_q == S_CLR_FLAG);
                    adr_d = (state_q == S_RD_MASK) ? MASK_ADDR : FLAG_ADDR;
                    dat_d = (state_q == S_CLR_FLAG) ? clr_word_s : 16'h0000;
                end else if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (state_q == S_RD_FLAG) begin
                        flag_d  = wbm_dat_i[NUM_SOURCES-1:0];
                        state_d = S_RD_MASK;
                    end else if (state_q == S_RD_MASK) begin
                        mask_d  = wbm_dat_i[NUM_SOURCES-1:0];
                        state_d = S_SELECT;
                    end else begin
                        state_d = S_HOLDOFF;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // ack on the final counted cycle wins over the timeout (checked above)
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_HOLDOFF;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SELECT: begin
                if (pending_s == '0) begin
                    spurious_d = 1'b1;
                    state_d    = S_HOLDOFF;
                end else begin
                    vec_d       = lowest_set(pending_s);
                    vec_valid_d = 1'b1;
                    state_d     = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (vec_ack_i) begin
                    vec_valid_d = 1'b0;
                    state_d     = S_CLR_FLAG;
                end else begin
                    state_d = S_DISPATCH;
                end
            end
            S_HOLDOFF: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                vec_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset clears everything without waiting for a clock.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 16'h0000;
            dat_q       <= 16'h0000;
            cnt_q       <= 16'd0;
            flag_q      <= '0;
            mask_q      <= '0;
            vec_valid_q <= 1'b0;
            vec_q       <= 4'd0;
            spurious_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            mask_q      <= mask_d;
            vec_valid_q <= vec_valid_d;
            vec_q       <= vec_d;
            spurious_q  <= spurious_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign vec_valid_o = vec_valid_q;
    assign vec_o       = vec_q;
    assign spurious_o  = spurious_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
endmodule

// File: doc/irq_dispatcher.md
IRQ_DISPATCHER -- requirements
Module: irq_dispatcher

Interface
REQ-001 Parameter NUM_SOURCES, default 5, number of flag bits serviced; bits [NUM_SOURCES-1:0] of the FLAG/MASK registers; legal range 1..16.
REQ-002 Parameter FLAG_ADDR, default `REG_IRQC_FLAG from irq_controller.vh, Wishbone address of the controller flag register.
REQ-003 Parameter MASK_ADDR, default `REG_IRQC_MASK from irq_controller.vh, Wishbone address of the controller mask register.
REQ-004 Parameter TIMEOUT, default 255, bus cycles without ack before a transaction is abandoned; legal range 1..65535.
REQ-005 wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-006 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-007 enable_i  in  1  dispatcher enable, sampled only in IDLE.
REQ-008 irq_i  in  1  interrupt request from the controller's irq_o.
REQ-009 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
REQ-010 wbm_adr_o  out  16, wbm_dat_o  out  16, wbm_dat_i  in  16, wbm_ack_i  in  1  Wishbone master address/data/ack.
REQ-011 vec_valid_o  out  1, vec_o  out  4, vec_ack_i  in  1  vector handshake to the interrupt consumer.
REQ-012 spurious_o  out  1  one-cycle pulse, no pending unmasked source found.
REQ-013 err_o  out  1  one-cycle pulse, bus timeout.
REQ-014 busy_o  out  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, RD_FLAG, RD_MASK, SELECT, DISPATCH, CLR_FLAG, HOLDOFF; all outputs registered.
REQ-016 IDLE -> RD_FLAG when enable_i=1 and irq_i=1 in the same cycle; otherwise remain.
REQ-017 RD_FLAG: cyc=stb=1, we=0, adr=FLAG_ADDR; on ack latch wbm_dat_i into flag_q, go RD_MASK.
REQ-018 RD_MASK: cyc=stb=1, we=0, adr=MASK_ADDR; on ack latch wbm_dat_i into mask_q, go SELECT.
REQ-019 Controller contract: mask bit 1 = source enabled; writing 0 to a FLAG bit clears it, writing 1 leaves it unchanged.
REQ-020 SELECT (one cycle): pending = flag_q & mask_q, bits [NUM_SOURCES-1:0] only; zero -> pulse spurious_o, go HOLDOFF; non-zero -> idx = lowest-numbered set bit (bit 0 highest priority), go DISPATCH.
REQ-021 DISPATCH: vec_valid_o=1, vec_o=idx, both held stable until vec_ack_i=1; on ack deassert vec_valid_o next cycle, go CLR_FLAG.
REQ-022 vec_ack_i while vec_valid_o=0 SHALL be ignored.
REQ-023 CLR_FLAG: cyc=stb=1, we=1, adr=FLAG_ADDR, dat=16'hFFFF with bit idx zero; on ack go HOLDOFF.
REQ-024 HOLDOFF: exactly one cycle, irq_i ignored (covers controller irq_o lag), then IDLE.
REQ-025 Bus rule: adr/we/dat stable while cyc=1; cyc/stb deasserted the cycle after ack, giving at least one idle cycle between consecutive transactions.
REQ-026 Each transaction counts cycles with cyc=1 and no ack; count reaching TIMEOUT -> drop cyc/stb, pulse err_o, go HOLDOFF; counter cleared at each transaction start.
REQ-027 ack in the same cycle the count reaches TIMEOUT SHALL be treated as success, no err_o.
REQ-028 enable_i deasserted mid-service SHALL not abort; service completes, then IDLE holds.
REQ-029 wbm_dat_i bits above NUM_SOURCES-1 SHALL be ignored; vec_o upper bits zero when NUM_SOURCES<=8.
REQ-030 Latency, zero-wait slave, valid pending source: irq_i sampled in IDLE at cycle N -> vec_valid_o high at cycle N+6.

Reset
REQ-031 wb_rst_i=1 forces immediately, without a clock edge: state=IDLE, all Wishbone outputs 0, wbm_adr_o/wbm_dat_o=0, vec_valid_o=0, vec_o=0, spurious_o=0, err_o=0, busy_o=0, flag_q/mask_q/counter=0.
REQ-032 Reset mid-transaction or mid-DISPATCH SHALL abandon it with no clear write issued; after release the block restarts from IDLE.

Verification
REQ-033 Flag=0x0006, mask=0x001F, irq_i=1 -> reads FLAG then MASK, vec_o=1, after vec_ack_i writes FLAG 0xFFFD, returns IDLE.
REQ-034 Flag=0x0003, mask=0x001C, irq_i=1 -> spurious_o one-cycle pulse, no vec_valid_o, no FLAG write.
REQ-035 Flag=0x0010 (user bit), mask=0x0010, vec_ack_i delayed 20 cycles -> vec_valid_o/vec_o=4 held stable all 20 cycles, then write 0xFFEF.
REQ-036 Slave never acks RD_FLAG, TIMEOUT=8 -> cyc dropped after 8 cycles, err_o one pulse, busy_o low 2 cycles later.
REQ-037 enable_i=0 with irq_i=1 -> no bus activity; enable_i raised -> service starts next cycle.
REQ-038 wb_rst_i asserted during CLR_FLAG with cyc=1 -> cyc/stb low before next clock edge, all outputs at reset values.
